// File: rtl/register_file.sv
// Architectural register file (x0..x31) with per-register ROB rename tags and two combinational operand reads.
// Optional same-cycle commit forwarding into reads is enabled by defining REGFILE_COMMIT_BYPASS_EN.

`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module register_file #(
    parameter int ROB_SIZE_BIT = `ROB_WIDTH_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic [4:0]              set_reg_id,
    input  logic [31:0]             set_val,
    input  logic [ROB_SIZE_BIT-1:0] set_reg_on_rob_id,
    input  logic [4:0]              set_dep_reg_id,
    input  logic [ROB_SIZE_BIT-1:0] set_dep_rob_id,
    input  logic [4:0]              get_id1,
    input  logic [4:0]              get_id2,
    output logic [31:0]             val1,
    output logic [31:0]             val2,
    output logic                    has_dep1,
    output logic                    has_dep2,
    output logic [ROB_SIZE_BIT-1:0] dep1,
    output logic [ROB_SIZE_BIT-1:0] dep2,
    output logic [ROB_SIZE_BIT-1:0] get_rob_id1,
    output logic [ROB_SIZE_BIT-1:0] get_rob_id2,
    input  logic                    rob_value1_ready,
    input  logic                    rob_value2_ready,
    input  logic [31:0]             rob_value1,
    input  logic [31:0]             rob_value2
);

    logic [31:0]             value_q [32];
    logic [31:0]             value_d [32];
    logic [31:0]             busy_q;
    logic [31:0]             busy_d;
    logic [ROB_SIZE_BIT-1:0] tag_q [32];
    logic [ROB_SIZE_BIT-1:0] tag_d [32];

    logic commit_en;
    logic rename_en;

    assign commit_en = (set_reg_id != 5'd0);
    assign rename_en = (set_dep_reg_id != 5'd0);

    // Rename is applied after commit so a same-register rename keeps ownership of busy/tag.
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (clear) begin
            busy_d = '0;
            for (int i = 0; i < 32; i++) begin
                tag_d[i] = '0;
            end
            if (rdy_in && commit_en) begin
                value_d[set_reg_id] = set_val;
            end
        end else if (rdy_in) begin
            if (commit_en) begin
                value_d[set_reg_id] = set_val;
                if (tag_q[set_reg_id] == set_reg_on_rob_id) begin
                    busy_d[set_reg_id] = 1'b0;
                end
            end
            if (rename_en) begin
                busy_d[set_dep_reg_id] = 1'b1;
                tag_d[set_dep_reg_id]  = set_dep_rob_id;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    // Operand port 1: final value, finished-in-ROB value, or pending producer tag.
    always_comb begin
        val1        = '0;
        has_dep1    = 1'b0;
        dep1        = '0;
        get_rob_id1 = '0;
        if (rst_in) begin
            get_rob_id1 = tag_q[get_id1];
            if (!busy_q[get_id1]) begin
                val1 = value_q[get_id1];
            end else if (rob_value1_ready) begin
                val1 = rob_value1;
`ifdef REGFILE_COMMIT_BYPASS_EN
            end else if (rdy_in && (get_id1 != 5'd0) && (set_reg_id == get_id1)
                         && (set_reg_on_rob_id == tag_q[get_id1])) begin
                val1 = set_val;
`endif
            end else begin
                has_dep1 = 1'b1;
                dep1     = tag_q[get_id1];
            end
        end
    end

    always_comb begin
        val2        = '0;
        has_dep2    = 1'b0;
        dep2        = '0;
        get_rob_id2 = '0;
        if (rst_in) begin
            get_rob_id2 = tag_q[get_id2];
            if (!busy_q[get_id2]) begin
                val2 = value_q[get_id2];
            end else if (rob_value2_ready) begin
                val2 = rob_value2;
`ifdef REGFILE_COMMIT_BYPASS_EN
            end else if (rdy_in && (get_id2 != 5'd0) && (set_reg_id == get_id2)
                         && (set_reg_on_rob_id == tag_q[get_id2])) begin
                val2 = set_val;
`endif
            end else begin
                has_dep2 = 1'b1;
                dep2     = tag_q[get_id2];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, rename/commit tag matching, clear, x0, stall and bypass.

module tb_register_file;

    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear;
    logic [4:0]    set_reg_id;
    logic [31:0]   set_val;
    logic [RB-1:0] set_reg_on_rob_id;
    logic [4:0]    set_dep_reg_id;
    logic [RB-1:0] set_dep_rob_id;
    logic [4:0]    get_id1;
    logic [4:0]    get_id2;
    logic [31:0]   val1;
    logic [31:0]   val2;
    logic          has_dep1;
    logic          has_dep2;
    logic [RB-1:0] dep1;
    logic [RB-1:0] dep2;
    logic [RB-1:0] get_rob_id1;
    logic [RB-1:0] get_rob_id2;
    logic          rob_value1_ready;
    logic          rob_value2_ready;
    logic [31:0]   rob_value1;
    logic [31:0]   rob_value2;

    int checkCount = 0;
    int errorCount = 0;

    register_file #(.ROB_SIZE_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
        .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
        .get_id1(get_id1), .get_id2(get_id2),
        .val1(val1), .val2(val2), .has_dep1(has_dep1), .has_dep2(has_dep2),
        .dep1(dep1), .dep2(dep2), .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
        .rob_value1(rob_value1), .rob_value2(rob_value2)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one commit/rename slot for the next edge, then advance past it.
    task automatic applyStimulus(input logic [4:0] cReg, input logic [31:0] cVal, input logic [RB-1:0] cRob,
                                 input logic [4:0] rReg, input logic [RB-1:0] rRob);
        set_reg_id        = cReg;
        set_val           = cVal;
        set_reg_on_rob_id = cRob;
        set_dep_reg_id    = rReg;
        set_dep_rob_id    = rRob;
        @(posedge clk_in);
        #1;
        set_reg_id     = 5'd0;
        set_val        = '0;
        set_reg_on_rob_id = '0;
        set_dep_reg_id = 5'd0;
        set_dep_rob_id = '0;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
        set_reg_id = '0; set_val = '0; set_reg_on_rob_id = '0;
        set_dep_reg_id = '0; set_dep_rob_id = '0;
        get_id1 = '0; get_id2 = '0;
        rob_value1_ready = 1'b0; rob_value2_ready = 1'b0;
        rob_value1 = '0; rob_value2 = '0;

        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            get_id1 = i[4:0];
            get_id2 = 5'(31 - i);
            #1;
            checkOutput($sformatf("reset_val1_x%0d", i), val1, 32'h0);
            checkOutput($sformatf("reset_dep1_x%0d", i), {31'b0, has_dep1}, 32'h0);
            checkOutput($sformatf("reset_dep2_x%0d", 31 - i), {31'b0, has_dep2}, 32'h0);
        end

        // Rename x5 -> tag 3, then resolve through ROB
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd5, 4'd3);
        get_id1 = 5'd5;
        #1;
        checkOutput("x5_has_dep", {31'b0, has_dep1}, 32'h1);
        checkOutput("x5_dep", {28'b0, dep1}, 32'd3);
        checkOutput("x5_get_rob_id", {28'b0, get_rob_id1}, 32'd3);
        rob_value1_ready = 1'b1; rob_value1 = 32'hDEAD;
        #1;
        checkOutput("x5_rob_val", val1, 32'hDEAD);
        checkOutput("x5_rob_has_dep", {31'b0, has_dep1}, 32'h0);
        checkOutput("x5_rob_dep", {28'b0, dep1}, 32'h0);
        rob_value1_ready = 1'b0; rob_value1 = '0;

        // Stale commit must not clear a younger rename
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd7, 4'd2);
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd7, 4'd4);
        applyStimulus(5'd7, 32'h11, 4'd2, 5'd0, 4'd0);
        get_id2 = 5'd7;
        #1;
        checkOutput("x7_stale_has_dep", {31'b0, has_dep2}, 32'h1);
        checkOutput("x7_stale_dep", {28'b0, dep2}, 32'd4);
        applyStimulus(5'd7, 32'h22, 4'd4, 5'd0, 4'd0);
        checkOutput("x7_final_val", val2, 32'h22);
        checkOutput("x7_final_has_dep", {31'b0, has_dep2}, 32'h0);

        // Same-cycle commit and rename of x9: rename wins
        applyStimulus(5'd9, 32'h55, 4'd1, 5'd9, 4'd6);
        get_id1 = 5'd9;
        #1;
        checkOutput("x9_has_dep", {31'b0, has_dep1}, 32'h1);
        checkOutput("x9_dep", {28'b0, dep1}, 32'd6);
        applyStimulus(5'd9, 32'h66, 4'd6, 5'd0, 4'd0);
        checkOutput("x9_after_val", val1, 32'h66);
        checkOutput("x9_after_has_dep", {31'b0, has_dep1}, 32'h0);

        // Clear with a same-cycle commit
        applyStimulus(5'd4, 32'h44, 4'd0, 5'd0, 4'd0);
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd3, 4'd1);
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd4, 4'd2);
        get_id1 = 5'd3; get_id2 = 5'd4;
        #1;
        checkOutput("x4_pre_clear_has_dep", {31'b0, has_dep2}, 32'h1);
        clear = 1'b1;
        applyStimulus(5'd3, 32'h77, 4'd5, 5'd0, 4'd0);
        clear = 1'b0;
        #1;
        checkOutput("x3_clear_val", val1, 32'h77);
        checkOutput("x3_clear_has_dep", {31'b0, has_dep1}, 32'h0);
        checkOutput("x4_clear_val", val2, 32'h44);
        checkOutput("x4_clear_has_dep", {31'b0, has_dep2}, 32'h0);
        checkOutput("x4_clear_rob_id", {28'b0, get_rob_id2}, 32'h0);

        // Writes to x0 ignored
        applyStimulus(5'd0, 32'h99, 4'd1, 5'd0, 4'd1);
        set_reg_id = 5'd0;
        get_id1 = 5'd0;
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd0, 4'd1);
        #1;
        checkOutput("x0_val", val1, 32'h0);
        checkOutput("x0_has_dep", {31'b0, has_dep1}, 32'h0);

        // Stall: commit to x8 with rdy_in low is dropped
        get_id2 = 5'd8;
        rdy_in = 1'b0;
        applyStimulus(5'd8, 32'h88, 4'd0, 5'd8, 4'd5);
        rdy_in = 1'b1;
        #1;
        checkOutput("x8_stall_val", val2, 32'h0);
        checkOutput("x8_stall_has_dep", {31'b0, has_dep2}, 32'h0);
        applyStimulus(5'd8, 32'h88, 4'd0, 5'd0, 4'd0);
        checkOutput("x8_commit_val", val2, 32'h88);

        // Commit of the pending producer in the same cycle as the read
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd10, 4'd7);
        get_id1 = 5'd10;
        set_reg_id = 5'd10; set_val = 32'hABC; set_reg_on_rob_id = 4'd7;
        #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        checkOutput("x10_bypass_val", val1, 32'hABC);
        checkOutput("x10_bypass_has_dep", {31'b0, has_dep1}, 32'h0);
`else
        checkOutput("x10_nobypass_has_dep", {31'b0, has_dep1}, 32'h1);
        checkOutput("x10_nobypass_dep", {28'b0, dep1}, 32'd7);
`endif
        applyStimulus(5'd10, 32'hABC, 4'd7, 5'd0, 4'd0);
        checkOutput("x10_committed_val", val1, 32'hABC);
        checkOutput("x10_committed_has_dep", {31'b0, has_dep1}, 32'h0);

        // Reset mid-operation discards pending tags and values
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd12, 4'd5);
        get_id1 = 5'd8; get_id2 = 5'd12;
        rst_in = 1'b0;
        #1;
        checkOutput("in_reset_val1", val1, 32'h0);
        checkOutput("in_reset_has_dep2", {31'b0, has_dep2}, 32'h0);
        checkOutput("in_reset_rob_id2", {28'b0, get_rob_id2}, 32'h0);
        applyStimulus(5'd0, 32'h0, 4'd0, 5'd0, 4'd0);
        rst_in = 1'b1;
        #1;
        checkOutput("post_reset_x8_val", val1, 32'h0);
        checkOutput("post_reset_x12_has_dep", {31'b0, has_dep2}, 32'h0);
        checkOutput("post_reset_x12_dep", {28'b0, dep2}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
